sram_sched: RTL and testbench
=============================

# sram_sched

Memory scheduler between the 8-bit host command interface, the dpu increment/decrement/shift unit and the single-port 32x32 SRAM macro. It buffers host commands in a 2-entry FIFO and launches dpu operations for commands with bit 7 set. It serves dpu read/write requests over the dpu's `requst_valid` handshake and arbitrates the one memory port round-robin between host and dpu traffic. Host accesses that would overtake an in-flight dpu operation on the same address are blocked.

## Interface
- No parameters. Depth 2, address width 5 and data width 32 are fixed.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `host_valid` in 1: command present.
- `host_ready` out 1: FIFO not full; a push occurs on `host_valid & host_ready`.
- `host_cmd` in 8: [7]=1 dpu op, [6:5] dpu mode, [4:0] address; [7]=0 host access.
- `host_we` in 1: for host access, 1=write, 0=read.
- `host_wdata` in 32: write data.
- `host_rvalid` out 1: one-cycle pulse carrying host read data.
- `host_rdata` out 32: read data, held until the next read returns.
- `busy` out 1: FIFO non-empty, dpu op in flight, or a read still outstanding.
- `dpu_load_cmd` out 1: one-cycle pulse loading `nxt_cmd` into the dpu.
- `nxt_cmd` out 8: command for the dpu.
- `requst_valid` out 1: grant/acknowledge to the dpu.
- `sram_data_read` out 32: read data to the dpu.
- `read_requst` in 1, `send_request` in 1: dpu requests.
- `sram_addr` in 5: dpu address.
- `sram_data_out` in 32: dpu result.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out 5, `mem_wdata` out 32: SRAM port. Outputs are combinational from the grant.
- `mem_rdata` in 32: valid the cycle after a read access.

## Operation
- **FIFO:** 2 entries of {cmd, we, wdata}, in-order. A push and a pop may occur in the same cycle. `host_ready=0` when full, so there is no push-when-full case.
- **Head classification:**
  - dpu cmd: eligible when `dpu_busy=0`.
  - Host access: eligible when not (`dpu_busy` and `cmd[4:0]==busy_addr`).
  - An ineligible head blocks the entries behind it.
- **Dpu launch:**
  - Popping an eligible dpu cmd registers `nxt_cmd<=cmd` and `dpu_load_cmd<=1` for the next cycle.
  - It sets `dpu_busy=1` and `busy_addr<=cmd[4:0]`.
  - The pop itself uses no memory slot.
- **Requesters per cycle:**
  - D: `read_requst & ~dpu_rd_pend`, or `send_request`.
  - H: eligible host-access head.
- **Arbitration:**
  - At most one grant per cycle.
  - If both D and H request, grant the one not granted last; `last_grant` updates on every grant and resets to host, so dpu wins the first contention.
  - No grant means `mem_en=0`.
- **Dpu read grant (cycle t):**
  - t: mem read at `sram_addr`; set `dpu_rd_pend`.
  - t+1: `requst_valid=1`, `sram_data_read=mem_rdata`; clear `dpu_rd_pend`.
  - `read_requst` is still high at t+1 and must not be re-granted.
- **Dpu write grant (cycle t):**
  - t: `mem_we=1`, `mem_addr=sram_addr`, `mem_wdata=sram_data_out`, `requst_valid=1`.
  - Clear `dpu_busy` at the end of t.
- **Host write grant:** mem write at t; pop at t.
- **Host read grant:** mem read at t; pop at t; `host_rdata<=mem_rdata` at t+1; `host_rvalid=1` during t+2.
- **Between dpu read and write:** the port is free during the dpu CAL cycle. Host traffic to other addresses is served there and during any dpu wait.
- **Dpu-only outputs:** `requst_valid=0` and `sram_data_read=0` in any cycle without a dpu grant or data return.

## Timing
- **Reset:** all outputs 0 except `host_ready=1`. FIFO is empty; `dpu_busy`, `dpu_rd_pend` and `last_grant` are cleared.
- **Reset mid-operation:** aborts everything, with no memory write after reset. The top level resets the dpu from the same reset so both sides restart IDLE.
- **Uncontended dpu op**, push at edge E:
  - E+1: pop.
  - E+2: `dpu_load_cmd`.
  - E+3: read grant.
  - E+4: `requst_valid` and data load.
  - E+5: CAL.
  - E+6: write grant with `requst_valid`.
  - 6 cycles from push to the write landing.
- **Uncontended host read:** push E, grant E+1, `host_rvalid` during E+3.
- **Host write:** push E, write during E+1.
- **Ordering:**
  - Write at t then read of the same address at t+1 returns the new data.
  - A dpu op to address A, followed by a host read of A, returns the post-op value.

## Test plan
- **Dpu op:** mem[3]=0x10; push cmd 0x83 (mode 00, addr 3); dpu `sram_data_out` = 0x11 → mem write of 0x11 to addr 3 at E+6; `dpu_load_cmd` and `requst_valid` pulses each one cycle.
- **Host ordering:** push write addr 5 = 0xDEADBEEF, then read addr 5 → mem write then mem read on consecutive cycles; `host_rvalid` with 0xDEADBEEF.
- **Hazard:** mem[7]=0x40; push 0xC7 (addr 7, mode 10), then host read addr 7 → host read is granted only after the dpu write; returns 0x80.
- **Contention:** dpu op on addr 1 while host reads addr 2 are queued back-to-back → port never carries two accesses in a cycle; grants alternate when both request; the host read is served in the dpu CAL cycle; values match the reference model.
- **Full FIFO:** push 3 commands on consecutive cycles while the head is blocked → `host_ready=0` after 2 entries; the third is accepted only after a pop; no command is lost or duplicated.
- **Reset mid-operation:** assert `rst` at E+4 of a dpu op → next cycle all outputs 0, `host_ready=1`; no write to the target address ever occurs.

Source files
------------

// File: rtl/sram_sched.sv
// Memory scheduler: buffers host commands in a 2-deep FIFO, launches dpu operations and
// shares the single SRAM port round-robin between host accesses and dpu requests.
module sram_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [7:0]  host_cmd,
  input  logic        host_we,
  input  logic [31:0] host_wdata,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        busy,
  output logic        dpu_load_cmd,
  output logic [7:0]  nxt_cmd,
  output logic        requst_valid,
  output logic [31:0] sram_data_read,
  input  logic        read_requst,
  input  logic        send_request,
  input  logic [4:0]  sram_addr,
  input  logic [31:0] sram_data_out,
  output logic        mem_en,
  output logic        mem_we,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {GRANT_HOST = 1'b0, GRANT_DPU = 1'b1} grant_t;

  logic [7:0]  fifoCmd_q  [2];
  logic        fifoWe_q   [2];
  logic [31:0] fifoData_q [2];
  logic        rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [1:0]  count_q, count_d;
  logic        dpuBusy_q, dpuBusy_d;
  logic [4:0]  busyAddr_q, busyAddr_d;
  logic        dpuRdPend_q, dpuRdPend_d;
  grant_t      lastGrant_q, lastGrant_d;
  logic        hostRdPend_q, hostRdPend_d;
  logic        hostRvalid_q, hostRvalid_d;
  logic [31:0] hostRdata_q, hostRdata_d;
  logic [7:0]  nxtCmd_q, nxtCmd_d;
  logic        dpuLoad_q, dpuLoad_d;

  logic [7:0]  headCmd;
  logic        headWe;
  logic [31:0] headData;
  logic        notEmpty, dpuPop, hostReq, dpuRdReq, dpuReq;
  logic        grantDpu, grantHost, dpuWrite, push, pop;

  // Head classification and the one-grant-per-cycle round-robin arbiter.
  always_comb begin
    headCmd   = fifoCmd_q[rdPtr_q];
    headWe    = fifoWe_q[rdPtr_q];
    headData  = fifoData_q[rdPtr_q];
    notEmpty  = (count_q != 2'd0);
    dpuPop    = notEmpty & headCmd[7] & ~dpuBusy_q;
    hostReq   = notEmpty & ~headCmd[7] & ~(dpuBusy_q & (headCmd[4:0] == busyAddr_q));
    dpuRdReq  = read_requst & ~dpuRdPend_q;
    dpuReq    = dpuRdReq | send_request;
    grantDpu  = ~rst & dpuReq & (~hostReq | (lastGrant_q == GRANT_HOST));
    grantHost = ~rst & hostReq & ~grantDpu;
    dpuWrite  = grantDpu & send_request;
    push      = host_valid & host_ready;
    pop       = dpuPop | grantHost;
  end

  always_comb begin
    host_ready     = (count_q != 2'd2);
    host_rvalid    = hostRvalid_q;
    host_rdata     = hostRdata_q;
    busy           = notEmpty | dpuBusy_q | hostRdPend_q | hostRvalid_q;
    dpu_load_cmd   = dpuLoad_q;
    nxt_cmd        = nxtCmd_q;
    requst_valid   = dpuRdPend_q | dpuWrite;
    sram_data_read = dpuRdPend_q ? mem_rdata : 32'd0;
    mem_en         = grantDpu | grantHost;
    mem_we         = dpuWrite | (grantHost & headWe);
    mem_addr       = 5'd0;
    mem_wdata      = 32'd0;
    if (grantDpu) begin
      mem_addr  = sram_addr;
      mem_wdata = dpuWrite ? sram_data_out : 32'd0;
    end else if (grantHost) begin
      mem_addr  = headCmd[4:0];
      mem_wdata = headWe ? headData : 32'd0;
    end
  end

  always_comb begin
    rdPtr_d      = pop ? ~rdPtr_q : rdPtr_q;
    wrPtr_d      = push ? ~wrPtr_q : wrPtr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    dpuBusy_d    = dpuBusy_q;
    if (dpuPop)        dpuBusy_d = 1'b1;
    else if (dpuWrite) dpuBusy_d = 1'b0;
    busyAddr_d   = dpuPop ? headCmd[4:0] : busyAddr_q;
    nxtCmd_d     = dpuPop ? headCmd : nxtCmd_q;
    dpuLoad_d    = dpuPop;
    dpuRdPend_d  = grantDpu & ~send_request;
    lastGrant_d  = lastGrant_q;
    if (grantDpu)       lastGrant_d = GRANT_DPU;
    else if (grantHost) lastGrant_d = GRANT_HOST;
    hostRdPend_d = grantHost & ~headWe;
    hostRvalid_d = hostRdPend_q;
    hostRdata_d  = hostRdPend_q ? mem_rdata : hostRdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q      <= 1'b0;
      wrPtr_q      <= 1'b0;
      count_q      <= 2'd0;
      dpuBusy_q    <= 1'b0;
      busyAddr_q   <= 5'd0;
      dpuRdPend_q  <= 1'b0;
      lastGrant_q  <= GRANT_HOST;
      hostRdPend_q <= 1'b0;
      hostRvalid_q <= 1'b0;
      hostRdata_q  <= 32'd0;
      nxtCmd_q     <= 8'd0;
      dpuLoad_q    <= 1'b0;
    end else begin
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
      dpuBusy_q    <= dpuBusy_d;
      busyAddr_q   <= busyAddr_d;
      dpuRdPend_q  <= dpuRdPend_d;
      lastGrant_q  <= lastGrant_d;
      hostRdPend_q <= hostRdPend_d;
      hostRvalid_q <= hostRvalid_d;
      hostRdata_q  <= hostRdata_d;
      nxtCmd_q     <= nxtCmd_d;
      dpuLoad_q    <= dpuLoad_d;
    end
  end

  // Payload storage needs no reset; only the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoCmd_q[wrPtr_q]  <= host_cmd;
      fifoWe_q[wrPtr_q]   <= host_we;
      fifoData_q[wrPtr_q] <= host_wdata;
    end
  end

endmodule

// File: tb/tb_sram_sched.sv
// Bench for sram_sched: SRAM and dpu behavioural models, directed timing scenarios
// and a randomized command stream checked against an in-order memory reference.
module tb_sram_sched;

  localparam int LOGN = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [7:0]  host_cmd = 8'd0;
  logic        host_we = 1'b0;
  logic [31:0] host_wdata = 32'd0;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        busy;
  logic        dpu_load_cmd;
  logic [7:0]  nxt_cmd;
  logic        requst_valid;
  logic [31:0] sram_data_read;
  logic        read_requst = 1'b0;
  logic        send_request = 1'b0;
  logic [4:0]  sram_addr = 5'd0;
  logic [31:0] sram_data_out = 32'd0;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sram_sched dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
    .host_we(host_we), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .busy(busy),
    .dpu_load_cmd(dpu_load_cmd), .nxt_cmd(nxt_cmd), .requst_valid(requst_valid),
    .sram_data_read(sram_data_read), .read_requst(read_requst), .send_request(send_request),
    .sram_addr(sram_addr), .sram_data_out(sram_data_out),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] dpuOp(input logic [1:0] mode, input logic [31:0] v);
    case (mode)
      2'b00:   return v + 32'd1;
      2'b01:   return v - 32'd1;
      2'b10:   return v << 1;
      default: return v >> 1;
    endcase
  endfunction

  // SRAM macro model; the poke port lets the bench preload contents while the DUT is idle.
  logic [31:0] sram [32];
  logic        pokeEn = 1'b0;
  logic [4:0]  pokeAddr = 5'd0;
  logic [31:0] pokeData = 32'd0;

  always @(posedge clk) begin
    if (pokeEn) sram[pokeAddr] <= pokeData;
    else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // dpu model: load, request read, one CAL cycle, request write.
  typedef enum logic [1:0] {D_IDLE, D_RD, D_CAL, D_WR} dState_t;
  dState_t     dState = D_IDLE;
  logic [1:0]  dMode = 2'd0;
  logic [31:0] dData = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      dState       <= D_IDLE;
      read_requst  <= 1'b0;
      send_request <= 1'b0;
    end else begin
      case (dState)
        D_IDLE: if (dpu_load_cmd) begin
          dMode       <= nxt_cmd[6:5];
          sram_addr   <= nxt_cmd[4:0];
          read_requst <= 1'b1;
          dState      <= D_RD;
        end
        D_RD: if (requst_valid) begin
          dData       <= sram_data_read;
          read_requst <= 1'b0;
          dState      <= D_CAL;
        end
        D_CAL: begin
          sram_data_out <= dpuOp(dMode, dData);
          send_request  <= 1'b1;
          dState        <= D_WR;
        end
        default: if (requst_valid) begin
          send_request <= 1'b0;
          dState       <= D_IDLE;
        end
      endcase
    end
  end

  // Reference: commands take effect in push order on a plain memory array.
  logic [31:0] refMem [32];
  logic [31:0] expQ [$];

  logic        logEn [LOGN];
  logic        logWe [LOGN];
  logic [4:0]  logAddr [LOGN];
  logic [31:0] logWdata [LOGN];
  logic        logRv [LOGN];
  logic        logLoad [LOGN];
  logic        logHrv [LOGN];
  logic [31:0] logHrd [LOGN];
  logic        logReady [LOGN];

  logic        watchOn = 1'b0;
  logic [4:0]  watchAddr = 5'd0;
  int          watchHits = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle log, read-return scoreboard and dpu-output idle check.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      logEn[cyc]    = mem_en;
      logWe[cyc]    = mem_we;
      logAddr[cyc]  = mem_addr;
      logWdata[cyc] = mem_wdata;
      logRv[cyc]    = requst_valid;
      logLoad[cyc]  = dpu_load_cmd;
      logHrv[cyc]   = host_rvalid;
      logHrd[cyc]   = host_rdata;
      logReady[cyc] = host_ready;
    end
    if (watchOn && mem_en && mem_we && mem_addr == watchAddr) watchHits++;
    if (!rst && host_rvalid) begin
      check32("rvalid_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) check32("host_rdata", host_rdata, expQ.pop_front());
    end
    if (!requst_valid) check32("sram_data_read_idle", sram_data_read, 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pokeMem(input logic [4:0] a, input logic [31:0] d);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    step(1);
    pokeEn = 1'b0;
    refMem[a] = d;
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic w, input logic [31:0] d,
                               output int pushCyc, output int waits);
    logic ok;
    host_valid = 1'b1; host_cmd = c; host_we = w; host_wdata = d;
    waits = 0;
    for (int i = 0; i < 200; i++) begin
      ok = host_ready;
      step(1);
      if (ok) break;
      waits++;
    end
    if (waits == 200) check32("push_timeout", 32'd1, 32'd0);
    pushCyc = cyc;
    if (c[7])    refMem[c[4:0]] = dpuOp(c[6:5], refMem[c[4:0]]);
    else if (w)  refMem[c[4:0]] = d;
    else         expQ.push_back(refMem[c[4:0]]);
  endtask

  task automatic idle();
    host_valid = 1'b0;
  endtask

  task automatic checkPort(input string tag, input int i, input logic en, input logic we,
                           input logic [4:0] a);
    check32({tag, "_en"}, 32'(logEn[i]), 32'(en));
    check32({tag, "_we"}, 32'(logWe[i]), 32'(we));
    check32({tag, "_addr"}, 32'(logAddr[i]), 32'(a));
  endtask

  task automatic checkOutput(input string tag);
    check32({tag, "_host_ready"}, 32'(host_ready), 32'd1);
    check32({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
    check32({tag, "_host_rdata"}, host_rdata, 32'd0);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_dpu_load_cmd"}, 32'(dpu_load_cmd), 32'd0);
    check32({tag, "_nxt_cmd"}, 32'(nxt_cmd), 32'd0);
    check32({tag, "_requst_valid"}, 32'(requst_valid), 32'd0);
    check32({tag, "_sram_data_read"}, sram_data_read, 32'd0);
    check32({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check32({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check32({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int c, w, w3;
    logic [31:0] saved;
    logic [7:0]  rc;
    logic [4:0]  ca [6];
    logic        cw [6];

    // Reset and initial state.
    rst = 1'b1;
    step(2);
    checkOutput("reset");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) pokeMem(5'(i), $urandom);

    // Uncontended dpu op: increment of mem[3].
    pokeMem(5'd3, 32'h10);
    applyStimulus(8'h83, 1'b0, 32'd0, c, w);
    idle();
    step(8);
    check32("dpu_load_early", 32'(logLoad[c]), 32'd0);
    check32("dpu_load_pulse", 32'(logLoad[c+1]), 32'd1);
    check32("dpu_load_single", 32'(logLoad[c+2]), 32'd0);
    checkPort("dpu_pop_noslot", c, 1'b0, 1'b0, 5'd0);
    checkPort("dpu_read", c+2, 1'b1, 1'b0, 5'd3);
    check32("dpu_rv_data", 32'(logRv[c+3]), 32'd1);
    checkPort("dpu_cal_free", c+4, 1'b0, 1'b0, 5'd0);
    check32("dpu_rv_cal", 32'(logRv[c+4]), 32'd0);
    checkPort("dpu_write", c+5, 1'b1, 1'b1, 5'd3);
    check32("dpu_wdata", logWdata[c+5], 32'h11);
    check32("dpu_rv_write", 32'(logRv[c+5]), 32'd1);
    check32("dpu_rv_after", 32'(logRv[c+6]), 32'd0);

    // Host write followed by read of the same address.
    applyStimulus(8'h05, 1'b1, 32'hDEADBEEF, c, w);
    applyStimulus(8'h05, 1'b0, 32'd0, w3, w);
    idle();
    step(6);
    checkPort("host_write", c, 1'b1, 1'b1, 5'd5);
    check32("host_wdata", logWdata[c], 32'hDEADBEEF);
    checkPort("host_read", c+1, 1'b1, 1'b0, 5'd5);
    check32("host_rvalid_early", 32'(logHrv[c+2]), 32'd0);
    check32("host_rvalid", 32'(logHrv[c+3]), 32'd1);
    check32("host_rdata_new", logHrd[c+3], 32'hDEADBEEF);

    // Hazard: host read of the dpu target waits for the dpu write.
    pokeMem(5'd7, 32'h40);
    applyStimulus(8'hC7, 1'b0, 32'd0, c, w);
    applyStimulus(8'h07, 1'b0, 32'd0, w3, w);
    idle();
    step(12);
    checkPort("hazard_blocked", c+1, 1'b0, 1'b0, 5'd0);
    checkPort("hazard_dpu_write", c+5, 1'b1, 1'b1, 5'd7);
    check32("hazard_wdata", logWdata[c+5], 32'h80);
    checkPort("hazard_host_read", c+6, 1'b1, 1'b0, 5'd7);
    check32("hazard_rdata", logHrd[c+8], 32'h80);

    // Contention: dpu op on addr 1 against four host reads of addr 2.
    ca = '{5'd2, 5'd1, 5'd2, 5'd2, 5'd1, 5'd2};
    cw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    applyStimulus(8'h81, 1'b0, 32'd0, c, w);
    for (int i = 0; i < 4; i++) applyStimulus(8'h02, 1'b0, 32'd0, w3, w);
    idle();
    check32("contention_push_wait", 32'(w), 32'd1);
    step(10);
    checkPort("contention_pop", c, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++)
      checkPort($sformatf("contention_c%0d", i + 1), c + 1 + i, 1'b1, cw[i], ca[i]);

    // Full FIFO behind a blocked head.
    applyStimulus(8'h89, 1'b0, 32'd0, c, w);
    applyStimulus(8'h09, 1'b1, 32'hCAFE0009, w3, w);
    applyStimulus(8'h09, 1'b0, 32'd0, w3, w);
    applyStimulus(8'h0A, 1'b0, 32'd0, w3, w);
    idle();
    check32("full_ready_low", 32'(logReady[c+2]), 32'd0);
    check32("full_third_wait", 32'(w), 32'd5);
    step(10);

    // Reset in the middle of a dpu op on addr 12.
    saved = refMem[12];
    applyStimulus(8'h8C, 1'b0, 32'd0, c, w);
    idle();
    step(3);
    rst = 1'b1;
    step(1);
    checkOutput("midreset");
    rst = 1'b0;
    refMem[12] = saved;
    watchAddr = 5'd12; watchHits = 0; watchOn = 1'b1;
    step(20);
    watchOn = 1'b0;
    check32("midreset_no_write", 32'(watchHits), 32'd0);
    check32("midreset_mem12", sram[12], saved);

    // Randomized command stream over a small address window to provoke hazards.
    for (int n = 0; n < 150; n++) begin
      rc = ($urandom_range(0, 99) < 25) ? 8'h80 : 8'h00;
      rc[6:5] = 2'($urandom);
      rc[4:0] = 5'($urandom_range(0, 7));
      applyStimulus(rc, 1'($urandom), $urandom, c, w);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        step($urandom_range(1, 3));
      end
    end
    idle();
    for (int i = 0; i < 1000; i++) begin
      if (!busy && dState == D_IDLE) break;
      step(1);
    end
    step(4);
    check32("drain_busy", 32'(busy), 32'd0);
    check32("drain_expq", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 32; i++) check32($sformatf("final_mem%0d", i), sram[i], refMem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
